// File: rtl/branch_unit_bht.sv
// branch_unit_bht: EX-stage branch resolution with a 2-bit counter BHT.
// Evaluates all six B-type conditions directly on rs1/rs2, returns an
// IF-stage prediction from the BHT, trains it on resolve and emits a
// registered resolve/mispredict/redirect pulse one cycle after resolve.
// Optional feature macro: BRANCH_PERF_EN (branch/mispredict counters).
module branch_unit_bht #(
   parameter int XLEN     = 32,
   parameter int IDX_BITS = 6,
   parameter int CNT_W    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic            ex_kill,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   output logic            res_valid,
   output logic            res_taken,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   output logic            res_illegal,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mis_count
);

   localparam int DEPTH = 1 << IDX_BITS;

   logic                resolve;
   logic                legal;
   logic                taken;
   logic [IDX_BITS-1:0] upd_idx;
   logic [IDX_BITS-1:0] lk_idx;

   logic [1:0]      bht_q [DEPTH];
   logic [1:0]      bht_d [DEPTH];
   logic            res_valid_q, res_valid_d;
   logic            res_taken_q, res_taken_d;
   logic            mispredict_q, mispredict_d;
   logic            res_illegal_q, res_illegal_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   // PC bits outside the index field do not affect the table
   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0],
                             ex_pc[XLEN-1:IDX_BITS+2], ex_pc[1:0]};

   assign resolve = ex_valid & ex_is_branch & ~ex_kill;
   assign upd_idx = ex_pc[IDX_BITS+1:2];
   assign lk_idx  = if_pc[IDX_BITS+1:2];

   // Lookup reads the registered table, so a same-cycle update is not visible
   assign pred_taken = bht_q[lk_idx][1];

   // Branch condition decode; 010/011 are illegal and never taken
   always_comb begin
      legal = 1'b1;
      taken = 1'b0;
      case (ex_funct3)
         3'b000:  taken = (ex_rs1 == ex_rs2);
         3'b001:  taken = (ex_rs1 != ex_rs2);
         3'b100:  taken = ($signed(ex_rs1) <  $signed(ex_rs2));
         3'b101:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
         3'b110:  taken = (ex_rs1 <  ex_rs2);
         3'b111:  taken = (ex_rs1 >= ex_rs2);
         default: legal = 1'b0;
      endcase
   end

   // Saturating counter training for the resolving branch's entry
   always_comb begin
      bht_d = bht_q;
      if (resolve && legal) begin
         if (taken && bht_q[upd_idx] != 2'b11)
            bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
         else if (!taken && bht_q[upd_idx] != 2'b00)
            bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
   end

   // Next values of the resolution pulses; redirect_pc holds when idle
   always_comb begin
      res_valid_d   = resolve;
      res_taken_d   = resolve & legal & taken;
      mispredict_d  = resolve & legal & (taken ^ ex_pred_taken);
      res_illegal_d = resolve & ~legal;
      redirect_pc_d = redirect_pc_q;
      if (resolve)
         redirect_pc_d = taken ? ex_target : ex_pc + XLEN'(4);
   end

   // BHT storage; every entry restarts weakly not-taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) bht_q[i] <= 2'b01;
      end else begin
         bht_q <= bht_d;
      end
   end

   // Resolution output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q   <= 1'b0;
         res_taken_q   <= 1'b0;
         mispredict_q  <= 1'b0;
         res_illegal_q <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         res_valid_q   <= res_valid_d;
         res_taken_q   <= res_taken_d;
         mispredict_q  <= mispredict_d;
         res_illegal_q <= res_illegal_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign res_valid   = res_valid_q;
   assign res_taken   = res_taken_q;
   assign mispredict  = mispredict_q;
   assign res_illegal = res_illegal_q;
   assign redirect_pc = redirect_pc_q;

`ifdef BRANCH_PERF_EN
   logic [CNT_W-1:0] br_count_q, br_count_d;
   logic [CNT_W-1:0] mis_count_q, mis_count_d;

   // Saturating event counters, cleared only by reset
   always_comb begin
      br_count_d  = br_count_q;
      mis_count_d = mis_count_q;
      if (resolve && legal && br_count_q != '1)
         br_count_d = br_count_q + CNT_W'(1);
      if (mispredict_d && mis_count_q != '1)
         mis_count_d = mis_count_q + CNT_W'(1);
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count_q  <= '0;
         mis_count_q <= '0;
      end else begin
         br_count_q  <= br_count_d;
         mis_count_q <= mis_count_d;
      end
   end

   assign br_count  = br_count_q;
   assign mis_count = mis_count_q;
`else
   assign br_count  = '0;
   assign mis_count = '0;
`endif

endmodule

// File: tb/tb_branch_unit_bht.sv
// Directed self-checking bench for branch_unit_bht.
module tb_branch_unit_bht;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        ex_valid, ex_is_branch, ex_kill, ex_pred_taken;
   logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_target;
   logic [2:0]  ex_funct3;
   logic        res_valid, res_taken, mispredict, res_illegal;
   logic [31:0] redirect_pc;
   logic [31:0] br_count, mis_count;

   int errors = 0;
   int checks = 0;

`ifdef BRANCH_PERF_EN
   localparam logic [31:0] EXP_BR  = 32'd3;
   localparam logic [31:0] EXP_MIS = 32'd1;
`else
   localparam logic [31:0] EXP_BR  = 32'd0;
   localparam logic [31:0] EXP_MIS = 32'd0;
`endif

   always #5 clk = ~clk;

   branch_unit_bht dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_kill(ex_kill),
      .ex_pc(ex_pc), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .res_valid(res_valid), .res_taken(res_taken), .mispredict(mispredict),
      .redirect_pc(redirect_pc), .res_illegal(res_illegal),
      .br_count(br_count), .mis_count(mis_count)
   );

   // Present one branch for one cycle; returns 1 time unit after the edge
   task automatic drive_br(input logic [31:0] pc, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] tgt, input logic pred, input logic kill);
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_kill = kill;
      ex_pc = pc; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
      ex_target = tgt; ex_pred_taken = pred;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_kill = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; if_pc = 32'h40;
      ex_valid = 0; ex_is_branch = 0; ex_kill = 0; ex_pred_taken = 0;
      ex_pc = 0; ex_funct3 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_target = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0b want 0", pred_taken); end
      checks++; if ({res_valid, res_taken, mispredict, res_illegal} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {res_valid, res_taken, mispredict, res_illegal}); end
      checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %h want 0", redirect_pc); end
      checks++; if (br_count !== 32'h0 || mis_count !== 32'h0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", br_count, mis_count); end
   endtask

   task automatic test_beq;
      if_pc = 32'h100;
      drive_br(32'h100, 3'b000, 32'd5, 32'd5, 32'h80, 1'b0, 1'b0);
      checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got v=%0b t=%0b want 1 1", res_valid, res_taken); end
      checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL beq_mispredict: got %0b want 1", mispredict); end
      checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL beq_redirect: got %h want 00000080", redirect_pc); end
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_bht_trained: got %0b want 1", pred_taken); end
      @(posedge clk); #1;
      checks++; if ({res_valid, res_taken, mispredict} !== 3'b0) begin errors++; $display("FAIL beq_pulse_width: got %b want 000", {res_valid, res_taken, mispredict}); end
      checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL beq_redirect_hold: got %h want 00000080", redirect_pc); end
   endtask

   task automatic test_conditions;
      // BLT: -1 < 1 signed, predicted taken
      drive_br(32'h204, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h400, 1'b1, 1'b0);
      checks++; if (res_taken !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("FAIL blt: got t=%0b m=%0b want 1 0", res_taken, mispredict); end
      checks++; if (redirect_pc !== 32'h400) begin errors++; $display("FAIL blt_redirect: got %h want 00000400", redirect_pc); end
      // BLTU: 0xFFFFFFFF < 1 unsigned is false, predicted taken
      drive_br(32'h208, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h400, 1'b1, 1'b0);
      checks++; if (res_taken !== 1'b0 || mispredict !== 1'b1) begin errors++; $display("FAIL bltu: got t=%0b m=%0b want 0 1", res_taken, mispredict); end
      checks++; if (redirect_pc !== 32'h20C) begin errors++; $display("FAIL bltu_redirect: got %h want 0000020c", redirect_pc); end
      // BNE equal operands -> not taken
      drive_br(32'h210, 3'b001, 32'd7, 32'd7, 32'h500, 1'b0, 1'b0);
      checks++; if (res_taken !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL bne: got t=%0b m=%0b want 0 0", res_taken, mispredict); end
      // BGE: -2 >= -3 signed -> taken
      drive_br(32'h214, 3'b101, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h600, 1'b0, 1'b0);
      checks++; if (res_taken !== 1'b1 || redirect_pc !== 32'h600) begin errors++; $display("FAIL bge: got t=%0b pc=%h want 1 00000600", res_taken, redirect_pc); end
      // BGEU 1 >= 2 false at top of address space: pc+4 wraps to 0
      drive_br(32'hFFFF_FFFC, 3'b111, 32'd1, 32'd2, 32'h700, 1'b1, 1'b0);
      checks++; if (res_taken !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL bgeu_wrap: got t=%0b pc=%h want 0 00000000", res_taken, redirect_pc); end
   endtask

   task automatic test_saturation;
      if_pc = 32'h10;
      repeat (5) drive_br(32'h10, 3'b000, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_hi_pred: got %0b want 1", pred_taken); end
      // From 11 one not-taken leaves 10 (still predicts taken)
      drive_br(32'h10, 3'b001, 32'd0, 32'd0, 32'h0, 1'b1, 1'b0);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_hi_hold: got %0b want 1", pred_taken); end
      drive_br(32'h10, 3'b001, 32'd0, 32'd0, 32'h0, 1'b1, 1'b0);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_down: got %0b want 0", pred_taken); end
      repeat (4) drive_br(32'h10, 3'b001, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0);
      // From 00 one taken gives 01 (not taken), a second gives 10
      drive_br(32'h10, 3'b000, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_lo_hold: got %0b want 0", pred_taken); end
      drive_br(32'h10, 3'b000, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_lo_up: got %0b want 1", pred_taken); end
   endtask

   task automatic test_illegal_kill;
      if_pc = 32'h20;
      drive_br(32'h20, 3'b010, 32'd1, 32'd2, 32'h0, 1'b1, 1'b0);
      checks++; if (res_illegal !== 1'b1 || mispredict !== 1'b0 || res_taken !== 1'b0) begin errors++; $display("FAIL illegal: got i=%0b m=%0b t=%0b want 1 0 0", res_illegal, mispredict, res_taken); end
      // Entry must still be 01: one taken then predicts taken
      drive_br(32'h20, 3'b000, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0);
      checks++; if (pred_taken !== 1'b1 || res_illegal !== 1'b0) begin errors++; $display("FAIL illegal_no_update: got p=%0b i=%0b want 1 0", pred_taken, res_illegal); end
      if_pc = 32'h24;
      drive_br(32'h24, 3'b000, 32'd3, 32'd3, 32'h900, 1'b0, 1'b1);
      checks++; if ({res_valid, res_taken, mispredict, res_illegal} !== 4'b0) begin errors++; $display("FAIL kill_pulses: got %b want 0000", {res_valid, res_taken, mispredict, res_illegal}); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL kill_no_update: got %0b want 0", pred_taken); end
   endtask

   task automatic test_back_to_back;
      // Lookup of the index being trained sees the old value
      if_pc = 32'h28;
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_kill = 1'b0; ex_pc = 32'h28;
      ex_funct3 = 3'b000; ex_rs1 = 0; ex_rs2 = 0; ex_target = 32'hA0; ex_pred_taken = 1'b0;
      #1;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_lookup: got %0b want 0", pred_taken); end
      drive_br(32'h28, 3'b000, 32'd0, 32'd0, 32'hA0, 1'b0, 1'b0);
      checks++; if (res_valid !== 1'b1 || redirect_pc !== 32'hA0) begin errors++; $display("FAIL b2b_first: got v=%0b pc=%h want 1 000000a0", res_valid, redirect_pc); end
      drive_br(32'h2C, 3'b001, 32'd0, 32'd0, 32'hB0, 1'b0, 1'b0);
      checks++; if (res_valid !== 1'b1 || res_taken !== 1'b0 || redirect_pc !== 32'h30) begin errors++; $display("FAIL b2b_second: got v=%0b t=%0b pc=%h want 1 0 00000030", res_valid, res_taken, redirect_pc); end
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL b2b_trained: got %0b want 1", pred_taken); end
   endtask

   task automatic test_perf;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      drive_br(32'h100, 3'b000, 32'd1, 32'd1, 32'h80, 1'b1, 1'b0);
      drive_br(32'h100, 3'b001, 32'd1, 32'd2, 32'h80, 1'b1, 1'b0);
      drive_br(32'h100, 3'b101, 32'd3, 32'd5, 32'h80, 1'b1, 1'b0);
      drive_br(32'h100, 3'b011, 32'd3, 32'd5, 32'h80, 1'b1, 1'b0);
      drive_br(32'h100, 3'b000, 32'd3, 32'd3, 32'h80, 1'b0, 1'b1);
      checks++; if (br_count !== EXP_BR) begin errors++; $display("FAIL perf_br: got %0d want %0d", br_count, EXP_BR); end
      checks++; if (mis_count !== EXP_MIS) begin errors++; $display("FAIL perf_mis: got %0d want %0d", mis_count, EXP_MIS); end
   endtask

   task automatic test_async_reset;
      if_pc = 32'h100;
      #1;
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL pre_reset_pred: got %0b want 1", pred_taken); end
      // Branch in flight while reset drops mid-cycle
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_kill = 1'b0; ex_pc = 32'h100;
      ex_funct3 = 3'b000; ex_rs1 = 0; ex_rs2 = 0; ex_target = 32'h44; ex_pred_taken = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({res_valid, res_taken, mispredict, res_illegal} !== 4'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL async_reset_out: got %b pc=%h want 0000 0", {res_valid, res_taken, mispredict, res_illegal}, redirect_pc); end
      checks++; if (br_count !== 32'h0 || mis_count !== 32'h0) begin errors++; $display("FAIL async_reset_counts: got %0d/%0d want 0/0", br_count, mis_count); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL async_reset_bht: got %0b want 0", pred_taken); end
      @(posedge clk); #1;
      ex_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL inflight_dropped: got v=%0b pc=%h want 0 0", res_valid, redirect_pc); end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_conditions();
      test_saturation();
      test_illegal_kill();
      test_back_to_back();
      test_perf();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
